// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared state encoding, default widths and divisor helper for the clock divider
package clock_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_e;
    localparam int CNT_W_DEF   = 26;
    localparam int DIV_MIN_DEF = 2;
    function automatic logic [31:0] half(input logic [31:0] div);
        return div >> 1;
    endfunction
endpackage

// File: rtl/clock_div_core.sv
// clock_div_core: period counter, wrap detect and registered clock_out compare
module clock_div_core
    import clock_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic [CNT_W-1:0] div_act,
    output logic             wrap,
    output logic             zero,
    output logic             clock_out
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clock_out_q, clock_out_d;
    logic [31:0]      half_div;
    assign half_div  = half(32'(div_act));
    assign wrap      = run && (cnt_q == div_act - CNT_W'(1));
    assign zero      = cnt_q == '0;
    assign clock_out = clock_out_q;
    always_comb begin
        cnt_d       = (run && !wrap) ? cnt_q + CNT_W'(1) : '0;
        clock_out_d = run && (32'(cnt_q) < half_div);
    end
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            clock_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            clock_out_q <= clock_out_d;
        end
    end
endmodule

// File: rtl/clock_div_sequencer.sv
// clock_div_sequencer: run/stop FSM and divisor handshake around clock_div_core.
// Optional CLKDIV_PERIOD_CNT_EN adds a 16-bit wrap counter output period_cnt.
module clock_div_sequencer
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 50000000,
    parameter int DIV_MIN     = DIV_MIN_DEF
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_divisor,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clock_out,
    output logic             tick,
`ifdef CLKDIV_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             busy
);
    state_e           state_q;
    logic [CNT_W-1:0] div_q, pend_q;
    logic             pend_valid_q, err_q;
    logic             run, wrap, zero, xfer, bad;
    assign run       = state_q != IDLE;
    assign cfg_ready = !pend_valid_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign bad       = cfg_divisor < CNT_W'(DIV_MIN);
    assign cfg_err   = err_q;
    assign tick      = run && zero;
    assign busy      = run || pend_valid_q;
    clock_div_core #(.CNT_W(CNT_W)) u_core (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .run      (run),
        .div_act  (div_q),
        .wrap     (wrap),
        .zero     (zero),
        .clock_out(clock_out)
    );
    // A transfer while running only ever lands in pend; it is applied at the first wrap after it.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_q        <= CNT_W'(DIV_DEFAULT);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= xfer && bad;
            if (xfer && !bad && !run)
                div_q <= cfg_divisor;
            else if (wrap && pend_valid_q)
                div_q <= pend_q;
            if (xfer && !bad && run) begin
                pend_q       <= cfg_divisor;
                pend_valid_q <= 1'b1;
            end else if (wrap) begin
                pend_valid_q <= 1'b0;
            end
            state_q <= (state_q == IDLE) ? (enable ? RUN : IDLE) :
                       (state_q == RUN)  ? (enable ? RUN : STOP_PEND) :
                       wrap              ? IDLE : (enable ? RUN : STOP_PEND);
        end
    end
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] pcnt_q;
    assign period_cnt = pcnt_q;
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n)
            pcnt_q <= '0;
        else if (wrap)
            pcnt_q <= pcnt_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_clock_div_sequencer.sv
// tb_clock_div_sequencer: directed per-cycle vectors pushed to a scoreboard, checked by a negedge monitor
module tb_clock_div_sequencer;
    typedef struct {
        int         cyc;
        logic [4:0] e;
    } exp_t;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [25:0] cfg_divisor = '0;
    logic        cfg_ready, cfg_err, clock_out, tick, busy;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t x;

    clock_div_sequencer dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_divisor(cfg_divisor),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clock_out  (clock_out),
        .tick       (tick),
`ifdef CLKDIV_PERIOD_CNT_EN
        .period_cnt (period_cnt),
`endif
        .busy       (busy)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string name, input logic got, input logic want, input int c);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle %0d %s: got %b expected %b", c, name, got, want);
        end
    endtask

    // e = {clock_out, tick, cfg_ready, cfg_err, busy} expected during this cycle
    task automatic step(input bit rn, input bit en, input bit v, input int d, input logic [4:0] e);
        exp_t t;
        @(posedge clock_in);
        #1;
        reset_n     = rn;
        enable      = en;
        cfg_valid   = v;
        cfg_divisor = 26'(d);
        t.cyc = cyc;
        t.e   = e;
        q.push_back(t);
        cyc++;
    endtask

    always @(negedge clock_in) begin
        if (q.size() != 0) begin
            x = q.pop_front();
            chk("clock_out", clock_out, x.e[4], x.cyc);
            chk("tick",      tick,      x.e[3], x.cyc);
            chk("cfg_ready", cfg_ready, x.e[2], x.cyc);
            chk("cfg_err",   cfg_err,   x.e[1], x.cyc);
            chk("busy",      busy,      x.e[0], x.cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        step(0, 0, 0, 0, 5'b00100);
        // divisor 4 in IDLE, then run
        step(1, 0, 1, 4, 5'b00100);
        step(1, 1, 0, 0, 5'b00100);
        step(1, 1, 0, 0, 5'b01101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b00101);
        step(1, 1, 0, 0, 5'b01101);
        // divisor 6 offered at cnt==1
        step(1, 1, 1, 6, 5'b10101);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b00001);
        step(1, 1, 0, 0, 5'b01101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b00101);
        step(1, 1, 0, 0, 5'b00101);
        // back to 4
        step(1, 1, 1, 4, 5'b01101);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b00001);
        step(1, 1, 0, 0, 5'b00001);
        // divisor 1 rejected
        step(1, 1, 1, 1, 5'b01101);
        step(1, 1, 0, 0, 5'b10111);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b00101);
        step(1, 1, 0, 0, 5'b01101);
        // stop at cnt==1, period completes, IDLE
        step(1, 0, 0, 0, 5'b10101);
        step(1, 0, 0, 0, 5'b10101);
        step(1, 0, 0, 0, 5'b00101);
        step(1, 0, 0, 0, 5'b00100);
        step(1, 1, 0, 0, 5'b00100);
        step(1, 1, 0, 0, 5'b01101);
        // stop then re-raise at cnt==2
        step(1, 0, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b00101);
        // divisor 5
        step(1, 1, 1, 5, 5'b01101);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b00001);
        step(1, 1, 0, 0, 5'b01101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b00101);
        // transfer on the wrap cycle waits a whole period
        step(1, 1, 1, 4, 5'b00101);
        step(1, 1, 0, 0, 5'b01001);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b10001);
        step(1, 1, 0, 0, 5'b00001);
        step(1, 1, 0, 0, 5'b00001);
        step(1, 1, 0, 0, 5'b01101);
        // pending update then async reset at cnt==2
        step(1, 1, 1, 6, 5'b10101);
        step(0, 0, 0, 0, 5'b00100);
        step(0, 0, 0, 0, 5'b00100);
        step(1, 0, 0, 0, 5'b00100);
        // default divisor restored, pending divisor lost
        step(1, 1, 0, 0, 5'b00100);
        step(1, 1, 0, 0, 5'b01101);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 5'b10101);
        // DIV_MIN itself is accepted
        step(0, 0, 0, 0, 5'b00100);
        step(1, 0, 1, 2, 5'b00100);
        step(1, 1, 0, 0, 5'b00100);
        step(1, 1, 0, 0, 5'b01101);
        step(1, 1, 0, 0, 5'b10101);
        step(1, 1, 0, 0, 5'b01101);
        step(1, 1, 0, 0, 5'b10101);
        @(negedge clock_in);
        #1;
`ifdef CLKDIV_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd1) begin
            errors++;
            $display("FAIL period_cnt: got %0d expected 1", period_cnt);
        end
`endif
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
